// File: rtl/am_safety_pkg.sv
// Shared types and defaults for the AM carrier fault-shutdown sequencer.
package am_safety_pkg;

   localparam int unsigned AMP_W_DEF      = 16;
   localparam int unsigned STEP_DEF       = 256;
   localparam int unsigned RAMP_DIV_DEF   = 4;
   localparam int unsigned HOLDOFF_DEF    = 1024;
   localparam int unsigned WARN_SHIFT_DEF = 1;
   localparam int unsigned CNT_W          = 8;

   typedef enum logic [2:0] {
      ST_HOLD      = 3'd0,
      ST_RAMP_UP   = 3'd1,
      ST_RUN       = 3'd2,
      ST_RAMP_DOWN = 3'd3,
      ST_MUTED     = 3'd4
   } state_e;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } ramp_dir_e;

   // Trip counter stops at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/ramp_step_gen.sv
// Ramp step divider plus saturating add/sub of one STEP toward a target.
module ramp_step_gen
   import am_safety_pkg::*;
#(
   parameter int unsigned AMP_W    = AMP_W_DEF,
   parameter int unsigned STEP     = STEP_DEF,
   parameter int unsigned RAMP_DIV = RAMP_DIV_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             restart,
   input  ramp_dir_e        dir,
   input  logic [AMP_W-1:0] target,
   input  logic [AMP_W-1:0] cur,
   output logic [AMP_W-1:0] nxt_c,
   output logic             step_c
);

   localparam int unsigned DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int unsigned WIDE_W = AMP_W + 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RAMP_DIV - 1);
   localparam logic [WIDE_W-1:0] STEP_WIDE = WIDE_W'(STEP);

   logic [DIV_W-1:0]  div_q, div_d;
   logic [WIDE_W-1:0] cur_wide_c, sum_c, diff_c;

   // Strobe is kept independent of restart so no loop forms through the FSM.
   assign step_c = en && (div_q == DIV_LAST);

   always_comb begin
      div_d = div_q + DIV_W'(1);
      if (restart || !en || step_c) begin
         div_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   // One extra bit so the upward sum cannot wrap before clamping.
   always_comb begin
      cur_wide_c = {1'b0, cur};
      sum_c      = cur_wide_c + STEP_WIDE;
      diff_c     = cur_wide_c - STEP_WIDE;
      nxt_c      = '0;
      if (dir == DIR_UP) begin
         nxt_c = (sum_c > {1'b0, target}) ? target : sum_c[AMP_W-1:0];
      end else if (cur_wide_c > STEP_WIDE) begin
         nxt_c = diff_c[AMP_W-1:0];
      end
   end

endmodule

// File: rtl/am_fault_shutdown_seq.sv
// Watchdog-driven AM carrier gate: warning attenuation, click-free ramp-down on
// trip, sticky fault, and hold-off plus soft ramp-up after a host clear.
module am_fault_shutdown_seq
   import am_safety_pkg::*;
#(
   parameter int unsigned AMP_W      = AMP_W_DEF,
   parameter int unsigned STEP       = STEP_DEF,
   parameter int unsigned RAMP_DIV   = RAMP_DIV_DEF,
   parameter int unsigned HOLDOFF    = HOLDOFF_DEF,
   parameter int unsigned WARN_SHIFT = WARN_SHIFT_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             wd_triggered,
   input  logic             wd_warning,
   input  logic             host_clear,
   input  logic [AMP_W-1:0] amp_in,
   output logic [AMP_W-1:0] amp_out,
   output logic             rf_enable,
   output logic             fault_latched,
   output logic [CNT_W-1:0] fault_count,
   output logic [2:0]       state
);

   localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

   state_e             state_q, state_d;
   logic [AMP_W-1:0]   amp_q, amp_d;
   logic               rf_en_q, rf_en_d;
   logic               fault_q, fault_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;

   logic [AMP_W-1:0]   target_c;
   logic [AMP_W-1:0]   ramp_nxt_c;
   logic               ramp_step_c;
   logic               ramp_en_c;
   logic               ramp_restart_c;
   ramp_dir_e          ramp_dir_c;

   assign target_c       = wd_warning ? (amp_in >> WARN_SHIFT) : amp_in;
   assign ramp_en_c      = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
   assign ramp_dir_c     = (state_q == ST_RAMP_UP) ? DIR_UP : DIR_DOWN;
   // Only a direct ramp-up to ramp-down hop skips a non-ramp cycle that zeroes the divider.
   assign ramp_restart_c = (state_q == ST_RAMP_UP) && wd_triggered;

   ramp_step_gen #(
      .AMP_W    (AMP_W),
      .STEP     (STEP),
      .RAMP_DIV (RAMP_DIV)
   ) u_ramp (
      .clk     (clk),
      .rstn    (rstn),
      .en      (ramp_en_c),
      .restart (ramp_restart_c),
      .dir     (ramp_dir_c),
      .target  (target_c),
      .cur     (amp_q),
      .nxt_c   (ramp_nxt_c),
      .step_c  (ramp_step_c)
   );

   always_comb begin
      state_d = state_q;
      amp_d   = amp_q;
      rf_en_d = rf_en_q;
      fault_d = fault_q;
      cnt_d   = cnt_q;
      hold_d  = '0;
      case (state_q)
         ST_HOLD: begin
            amp_d   = '0;
            rf_en_d = 1'b0;
            if (wd_triggered) begin
               state_d = ST_MUTED;
               fault_d = 1'b1;
               cnt_d   = sat_inc(cnt_q);
            end else if (hold_q == HOLD_LAST) begin
               state_d = ST_RAMP_UP;
               rf_en_d = 1'b1;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         ST_RAMP_UP: begin
            if (wd_triggered) begin
               state_d = ST_RAMP_DOWN;
               fault_d = 1'b1;
               cnt_d   = sat_inc(cnt_q);
            end else if (target_c < amp_q) begin
               amp_d   = target_c;
               state_d = ST_RUN;
            end else if (ramp_step_c) begin
               amp_d = ramp_nxt_c;
               if (ramp_nxt_c == target_c) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (wd_triggered) begin
               state_d = ST_RAMP_DOWN;
               fault_d = 1'b1;
               cnt_d   = sat_inc(cnt_q);
            end else begin
               amp_d = target_c;
            end
         end
         ST_RAMP_DOWN: begin
            if (amp_q == '0) begin
               state_d = ST_MUTED;
               rf_en_d = 1'b0;
            end else if (ramp_step_c) begin
               amp_d = ramp_nxt_c;
               if (ramp_nxt_c == '0) begin
                  state_d = ST_MUTED;
                  rf_en_d = 1'b0;
               end
            end
         end
         ST_MUTED: begin
            amp_d   = '0;
            rf_en_d = 1'b0;
            fault_d = 1'b1;
            if (host_clear && !wd_triggered) begin
               state_d = ST_HOLD;
               fault_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_HOLD;
            amp_d   = '0;
            rf_en_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_HOLD;
         amp_q   <= '0;
         rf_en_q <= 1'b0;
         fault_q <= 1'b0;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         amp_q   <= amp_d;
         rf_en_q <= rf_en_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

   assign amp_out       = amp_q;
   assign rf_enable     = rf_en_q;
   assign fault_latched = fault_q;
   assign fault_count   = cnt_q;
   assign state         = state_q;

endmodule

// File: tb/tb_am_fault_shutdown_seq.sv
// Randomized and directed bench for am_fault_shutdown_seq against a behavioural model.
module tb_am_fault_shutdown_seq;

   localparam int AMP_W      = 16;
   localparam int STEP       = 256;
   localparam int RAMP_DIV   = 4;
   localparam int HOLDOFF    = 8;
   localparam int WARN_SHIFT = 1;

   logic             clk = 1'b0;
   logic             rstn;
   logic             wd_triggered;
   logic             wd_warning;
   logic             host_clear;
   logic [AMP_W-1:0] amp_in;
   logic [AMP_W-1:0] amp_out;
   logic             rf_enable;
   logic             fault_latched;
   logic [7:0]       fault_count;
   logic [2:0]       state;
   logic [28:0]      dut_vec;

   int checks = 0;
   int errors = 0;

   // Model: mode uses the published state numbering; age = edges spent in the mode.
   int m_mode, m_amp, m_rf, m_fl, m_cnt, m_age, m_base;

   am_fault_shutdown_seq #(
      .AMP_W      (AMP_W),
      .STEP       (STEP),
      .RAMP_DIV   (RAMP_DIV),
      .HOLDOFF    (HOLDOFF),
      .WARN_SHIFT (WARN_SHIFT)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .wd_triggered  (wd_triggered),
      .wd_warning    (wd_warning),
      .host_clear    (host_clear),
      .amp_in        (amp_in),
      .amp_out       (amp_out),
      .rf_enable     (rf_enable),
      .fault_latched (fault_latched),
      .fault_count   (fault_count),
      .state         (state)
   );

   always #5 clk = ~clk;

   assign dut_vec = {amp_out, rf_enable, fault_latched, fault_count, state};

   function automatic void model_reset();
      m_mode = 0; m_amp = 0; m_rf = 0; m_fl = 0; m_cnt = 0; m_age = 0; m_base = 0;
   endfunction

   function automatic void model_trip(input int to_mode);
      m_fl  = 1;
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_base = m_amp;
      m_mode = to_mode;
   endfunction

   function automatic void model_step();
      int tgt, prev, steps;
      bit step_now;
      prev     = m_mode;
      tgt      = wd_warning ? (int'(amp_in) >> WARN_SHIFT) : int'(amp_in);
      step_now = ((m_age + 1) % RAMP_DIV) == 0;
      case (m_mode)
         0: begin
            if (wd_triggered) model_trip(4);
            else if (m_age + 1 == HOLDOFF) begin m_mode = 1; m_rf = 1; end
         end
         1: begin
            if (wd_triggered) model_trip(3);
            else if (tgt < m_amp) begin m_amp = tgt; m_mode = 2; end
            else if (step_now) begin
               m_amp = (m_amp + STEP > tgt) ? tgt : m_amp + STEP;
               if (m_amp == tgt) m_mode = 2;
            end
         end
         2: begin
            if (wd_triggered) model_trip(3);
            else m_amp = tgt;
         end
         3: begin
            if (m_amp == 0) begin m_mode = 4; m_rf = 0; end
            else begin
               steps = (m_age + 1) / RAMP_DIV;
               m_amp = (m_base > STEP * steps) ? m_base - STEP * steps : 0;
               if (m_amp == 0) begin m_mode = 4; m_rf = 0; end
            end
         end
         default: begin
            if (host_clear && !wd_triggered) begin m_mode = 0; m_fl = 0; end
         end
      endcase
      m_age = (m_mode == prev) ? m_age + 1 : 0;
   endfunction

   function automatic logic [28:0] exp_vec();
      return {16'(m_amp), 1'(m_rf), 1'(m_fl), 8'(m_cnt), 3'(m_mode)};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; wd_triggered = 1'b0; wd_warning = 1'b0; host_clear = 1'b0; amp_in = '0;
      model_reset();
      #1;
      checks++;
      if (dut_vec !== 29'd0)
         begin errors++; $display("FAIL reset_values got=%h exp=%h", dut_vec, 29'd0); end
      repeat (2) @(posedge clk);
      #3 rstn = 1'b1;
   endtask

   task automatic test_ramp_up();
      amp_in = 16'h1000;
      for (int c = 1; c <= 80; c++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec())
            begin errors++; $display("FAIL ramp_up_model cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
         if (c == 7 || c == 8) begin
            checks++;
            if (rf_enable !== (c == 8))
               begin errors++; $display("FAIL ramp_up_rf_rise cyc=%0d got=%b exp=%b", c, rf_enable, (c == 8)); end
         end
         if (c == 12) begin
            checks++;
            if (amp_out !== 16'h0100)
               begin errors++; $display("FAIL ramp_up_first_step got=%h exp=0100", amp_out); end
         end
         if (c == 71 || c == 72) begin
            checks++;
            if ({amp_out, state} !== ((c == 71) ? {16'h0F00, 3'd1} : {16'h1000, 3'd2}))
               begin errors++; $display("FAIL ramp_up_reach_run cyc=%0d got amp=%h st=%0d", c, amp_out, state); end
         end
      end
   endtask

   task automatic test_warning();
      wd_warning = 1'b1;
      tick();
      checks++;
      if (amp_out !== 16'h0800 || dut_vec !== exp_vec())
         begin errors++; $display("FAIL warning_halve got=%h exp=0800", amp_out); end
      wd_warning = 1'b0;
      tick();
      checks++;
      if (amp_out !== 16'h1000 || dut_vec !== exp_vec())
         begin errors++; $display("FAIL warning_release got=%h exp=1000", amp_out); end
      for (int i = 0; i < 20; i++) begin
         amp_in = 16'($urandom);
         wd_warning = 1'($urandom_range(0, 1));
         tick();
         checks++;
         if (dut_vec !== exp_vec())
            begin errors++; $display("FAIL warning_random i=%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
      end
      amp_in = 16'h1000; wd_warning = 1'b0;
      tick();
   endtask

   task automatic test_trip();
      wd_triggered = 1'b1;
      tick();
      wd_triggered = 1'b0;
      checks++;
      if ({fault_latched, fault_count, state, amp_out} !== {1'b1, 8'd1, 3'd3, 16'h1000} || dut_vec !== exp_vec())
         begin errors++; $display("FAIL trip_entry got fl=%b cnt=%0d st=%0d amp=%h", fault_latched, fault_count, state, amp_out); end
      for (int k = 1; k <= 70; k++) begin
         amp_in = 16'($urandom);
         wd_warning = 1'($urandom_range(0, 1));
         tick();
         checks++;
         if (dut_vec !== exp_vec())
            begin errors++; $display("FAIL trip_ramp_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec()); end
         if (k == 63 || k == 64) begin
            checks++;
            if ({amp_out, rf_enable, state} !== ((k == 63) ? {16'h0100, 1'b1, 3'd3} : {16'h0000, 1'b0, 3'd4}))
               begin errors++; $display("FAIL trip_mute k=%0d got amp=%h rf=%b st=%0d", k, amp_out, rf_enable, state); end
         end
      end
      wd_warning = 1'b0;
   endtask

   task automatic test_clear();
      wd_triggered = 1'b1; host_clear = 1'b1;
      tick();
      host_clear = 1'b0;
      repeat (2) tick();
      checks++;
      if ({state, fault_latched} !== {3'd4, 1'b1} || dut_vec !== exp_vec())
         begin errors++; $display("FAIL clear_blocked got st=%0d fl=%b", state, fault_latched); end
      wd_triggered = 1'b0;
      tick();
      host_clear = 1'b1;
      tick();
      host_clear = 1'b0;
      checks++;
      if ({state, fault_latched, fault_count, amp_out} !== {3'd0, 1'b0, 8'd1, 16'h0000} || dut_vec !== exp_vec())
         begin errors++; $display("FAIL clear_to_hold got st=%0d fl=%b cnt=%0d", state, fault_latched, fault_count); end
      amp_in = 16'h0150;
      for (int c = 1; c <= 20; c++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec())
            begin errors++; $display("FAIL clear_ramp_model cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
         if (c == 12 || c == 16) begin
            checks++;
            if ({amp_out, state} !== ((c == 12) ? {16'h0100, 3'd1} : {16'h0150, 3'd2}))
               begin errors++; $display("FAIL clear_clamp cyc=%0d got amp=%h st=%0d", c, amp_out, state); end
         end
      end
      checks++;
      if (fault_count !== 8'd1)
         begin errors++; $display("FAIL clear_count_kept got=%0d exp=1", fault_count); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 31) == 0) amp_in = 16'($urandom);
         if ($urandom_range(0, 15) == 0) wd_warning = ~wd_warning;
         if (!wd_triggered) wd_triggered = ($urandom_range(0, 199) == 0);
         else               wd_triggered = ($urandom_range(0, 3) != 0);
         host_clear = ($urandom_range(0, 15) == 0);
         tick();
         checks++;
         if (dut_vec !== exp_vec())
            begin errors++; $display("FAIL random_model i=%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
      end
      host_clear = 1'b0; wd_warning = 1'b0;
   endtask

   task automatic test_saturate();
      int budget;
      wd_triggered = 1'b1;
      budget = 0;
      while (m_mode != 4 && budget < 1200) begin
         tick();
         budget++;
      end
      checks++;
      if (state !== 3'd4 || dut_vec !== exp_vec())
         begin errors++; $display("FAIL sat_reach_muted got st=%0d vec=%h exp=%h", state, dut_vec, exp_vec()); end
      for (int i = 0; i < 260; i++) begin
         wd_triggered = 1'b0; host_clear = 1'b1;
         tick();
         host_clear = 1'b0; wd_triggered = 1'b1;
         tick();
         checks++;
         if (dut_vec !== exp_vec())
            begin errors++; $display("FAIL sat_hold_trip i=%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
      end
      checks++;
      if (fault_count !== 8'd255)
         begin errors++; $display("FAIL sat_count got=%0d exp=255", fault_count); end
      wd_triggered = 1'b0;
   endtask

   task automatic test_reset_mid_rampdown();
      host_clear = 1'b1;
      tick();
      host_clear = 1'b0; amp_in = 16'h1000;
      repeat (40) tick();
      wd_triggered = 1'b1;
      tick();
      wd_triggered = 1'b0;
      repeat (10) tick();
      checks++;
      if (state !== 3'd3 || dut_vec !== exp_vec())
         begin errors++; $display("FAIL rst_pre_state got st=%0d vec=%h exp=%h", state, dut_vec, exp_vec()); end
      #2 rstn = 1'b0;
      #1;
      model_reset();
      checks++;
      if (dut_vec !== 29'd0)
         begin errors++; $display("FAIL rst_async got=%h exp=%h", dut_vec, 29'd0); end
      repeat (2) @(posedge clk);
      #3 rstn = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec())
            begin errors++; $display("FAIL rst_restart cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
      end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_warning();
      test_trip();
      test_clear();
      test_random();
      test_saturate();
      test_reset_mid_rampdown();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/am_fault_shutdown_seq.md
Name: am_fault_shutdown_seq

Overview:
- Sits directly downstream of watchdog_timer and consumes its `triggered` and `warning` outputs.
- Gates the amplitude word fed to the AM modulator and drives the RF-enable line.
- On watchdog warning it halves amplitude. On trigger it ramps the carrier down click-free, mutes it and latches a fault.
- After a host clear it restarts through a hold-off and a soft ramp-up.

Parameters:
- AMP_W, 16, width of amplitude words.
- STEP, 256, amplitude change per ramp step.
- RAMP_DIV, 4, clock cycles per ramp step (≥1).
- HOLDOFF, 1024, cycles held muted before ramp-up (≥1).
- WARN_SHIFT, 1, right-shift applied to amplitude while warning is active.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- wd_triggered  in  1  watchdog timeout, level.
- wd_warning  in  1  watchdog pre-timeout warning, level.
- host_clear  in  1  single-cycle fault-clear request.
- amp_in  in  AMP_W  requested amplitude.
- amp_out  out  AMP_W  gated amplitude to modulator, registered.
- rf_enable  out  1  RF output stage enable.
- fault_latched  out  1  sticky fault flag.
- fault_count  out  8  saturating count of watchdog-trip events.
- state  out  3  current FSM state: HOLD=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, MUTED=4.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rstn.
- Reset values: state=HOLD, amp_out=0, rf_enable=0, fault_latched=0, fault_count=0; hold-off and divider counters at 0.
- target = wd_warning ? (amp_in >> WARN_SHIFT) : amp_in. Evaluated every cycle.
- HOLD:
  - amp_out=0, rf_enable=0.
  - Counts HOLDOFF cycles, then goes to RAMP_UP. rf_enable=1 from the first RAMP_UP cycle.
  - wd_triggered in HOLD → MUTED directly, fault_latched=1, fault_count increments.
- RAMP_UP:
  - Divider restarts on entry. The first step occurs RAMP_DIV cycles after entry.
  - Each step: amp_out = min(amp_out+STEP, target). Compute at AMP_W+1 bits so the addition cannot wrap.
  - If target falls below amp_out, amp_out = target on the next cycle.
  - amp_out==target after an update → RUN.
  - wd_triggered → RAMP_DOWN.
- RUN:
  - amp_out <= target every cycle (1-cycle latency).
  - wd_triggered → RAMP_DOWN.
- RAMP_DOWN:
  - On entry cycle: fault_latched=1, fault_count += 1, saturating at 255.
  - Divider restarts. Each step: amp_out = (amp_out>STEP) ? amp_out-STEP : 0. amp_in is ignored.
  - rf_enable stays 1 until amp_out reaches 0, then → MUTED.
  - If amp_out is already 0 on entry → MUTED next cycle.
- MUTED:
  - amp_out=0, rf_enable=0, fault_latched=1.
  - host_clear with wd_triggered=0 → HOLD, fault_latched cleared the same edge.
  - host_clear with wd_triggered=1 is ignored (not queued).
- Simultaneous events:
  - wd_triggered has priority over any state transition.
  - host_clear outside MUTED has no effect.
- fault_count is cleared only by rstn.
- rstn assertion mid-ramp forces all outputs to reset values immediately (asynchronously).

Decomposition:
- Shared package (`am_safety_pkg`): state enum (3-bit encoding above), STEP/RAMP_DIV/HOLDOFF default constants, AMP_W.
- Sub-module `ramp_step_gen`: divider counter plus saturating add/sub toward a target. It takes dir, target, cur and restart, and produces next value and step strobe. Used by both ramp states.

Test Plan (STEP=256, RAMP_DIV=4, HOLDOFF=8):
- Release rstn, amp_in=0x1000, no watchdog → rf_enable rises 8 cycles after release; amp_out steps 0x100 every 4 cycles; reaches 0x1000 after 64 cycles; state=RUN.
- In RUN, amp_in=0x1000, assert wd_warning → amp_out=0x0800 one cycle later. Drop wd_warning → 0x1000 one cycle later.
- In RUN with amp_out=0x1000, pulse wd_triggered:
  - fault_latched=1 and fault_count=1 after 1 cycle.
  - amp_out decrements 0x100 per 4 cycles, reaching 0 after 64 cycles.
  - rf_enable=0 and state=MUTED.
- In MUTED:
  - host_clear with wd_triggered=1 → remains MUTED.
  - Drop wd_triggered, then host_clear → HOLD with fault_latched=0; ramp-up repeats; fault_count remains 1.
- amp_in=0x0150 during RAMP_UP → amp_out 0x0100, then 0x0150 (clamped), then RUN.
- Assert rstn low mid-RAMP_DOWN → amp_out=0, rf_enable=0, fault_latched=0, fault_count=0, state=HOLD without waiting for a clock edge.
